// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction queue between the fetch stage and the decoder.
// Holds fetched instructions with PC, branch prediction and fetch-fault info,
// and hands them to the decoder in order over a valid/ready handshake.
// A single-cycle flush empties the queue on a redirect.
// Optional feature: define FETCH_FIFO_BYPASS_EN to forward an incoming entry
// straight to the decoder when the queue is empty (zero-cycle latency).
module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [63:0]              in_pc_i,
    input  logic [31:0]              in_instr_i,
    input  logic                     in_pred_taken_i,
    input  logic [63:0]              in_pred_target_i,
    input  logic                     in_ex_valid_i,
    input  logic [63:0]              in_ex_cause_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_pc_o,
    output logic [31:0]              out_instr_o,
    output logic                     out_pred_taken_o,
    output logic [63:0]              out_pred_target_o,
    output logic                     out_ex_valid_o,
    output logic [63:0]              out_ex_cause_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [63:0] pc_mem     [DEPTH];
    logic [31:0] instr_mem  [DEPTH];
    logic        taken_mem  [DEPTH];
    logic [63:0] target_mem [DEPTH];
    logic        exv_mem    [DEPTH];
    logic [63:0] cause_mem  [DEPTH];

    logic push;
    logic pop;
    logic bypass_take;
    logic wr_en;
    logic rd_en;

    // A full queue never accepts, even with a pop in the same cycle; flush masks it too.
    assign in_ready_o = (count < FULL_COUNT) && !flush_i;
    assign count_o    = count;

    // Head presentation: stored entry at the read pointer, or the live input when bypassing.
    always_comb begin
        out_valid_o       = (count != '0) && !flush_i;
        out_pc_o          = pc_mem[rd_ptr];
        out_instr_o       = instr_mem[rd_ptr];
        out_pred_taken_o  = taken_mem[rd_ptr];
        out_pred_target_o = target_mem[rd_ptr];
        out_ex_valid_o    = exv_mem[rd_ptr];
        out_ex_cause_o    = cause_mem[rd_ptr];
        bypass_take       = 1'b0;
`ifdef FETCH_FIFO_BYPASS_EN
        if ((count == '0) && !flush_i) begin
            out_valid_o       = in_valid_i;
            out_pc_o          = in_pc_i;
            out_instr_o       = in_instr_i;
            out_pred_taken_o  = in_pred_taken_i;
            out_pred_target_o = in_pred_target_i;
            out_ex_valid_o    = in_ex_valid_i;
            out_ex_cause_o    = in_ex_valid_i ? in_ex_cause_i : 64'd0;
            bypass_take       = in_valid_i && out_ready_i;
        end
`endif
    end

    // An entry consumed through the bypass is neither written nor read from storage.
    assign push  = in_valid_i && in_ready_o;
    assign pop   = out_valid_o && out_ready_i;
    assign wr_en = push && !bypass_take;
    assign rd_en = pop && !bypass_take;

    // Pointer and occupancy bookkeeping; flush returns everything to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head fields read zero, cause masked when no fault.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]     <= '0;
                instr_mem[i]  <= '0;
                taken_mem[i]  <= 1'b0;
                target_mem[i] <= '0;
                exv_mem[i]    <= 1'b0;
                cause_mem[i]  <= '0;
            end
        end else if (wr_en) begin
            pc_mem[wr_ptr]     <= in_pc_i;
            instr_mem[wr_ptr]  <= in_instr_i;
            taken_mem[wr_ptr]  <= in_pred_taken_i;
            target_mem[wr_ptr] <= in_pred_target_i;
            exv_mem[wr_ptr]    <= in_ex_valid_i;
            cause_mem[wr_ptr]  <= in_ex_valid_i ? in_ex_cause_i : 64'd0;
        end
    end

endmodule

// File: tb/tb_fetch_fifo.sv
// tb_fetch_fifo: self-checking bench for fetch_fifo (DEPTH=4).
// Table-driven fill/drain vectors, hand sequences for flush, exceptions,
// wrap-around streaming and async reset, then randomized traffic against a
// queue-based reference model. Expectations follow FETCH_FIFO_BYPASS_EN if defined.
module tb_fetch_fifo;

    localparam int DEPTH = 4;
`ifdef FETCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_pred_taken;
    logic [63:0] in_pred_target;
    logic        in_ex_valid;
    logic [63:0] in_ex_cause;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;
    logic [63:0] out_pred_target;
    logic        out_ex_valid;
    logic [63:0] out_ex_cause;
    logic [2:0]  count;

    int total;
    int bad;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [63:0] pc;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [63:0] exp_pc;
        int          exp_count;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [63:0] target;
        logic        exv;
        logic [63:0] cause;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];

    fetch_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_pc_i           (in_pc),
        .in_instr_i        (in_instr),
        .in_pred_taken_i   (in_pred_taken),
        .in_pred_target_i  (in_pred_target),
        .in_ex_valid_i     (in_ex_valid),
        .in_ex_cause_i     (in_ex_cause),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_pc_o          (out_pc),
        .out_instr_o       (out_instr),
        .out_pred_taken_o  (out_pred_taken),
        .out_pred_target_o (out_pred_target),
        .out_ex_valid_o    (out_ex_valid),
        .out_ex_cause_o    (out_ex_cause),
        .count_o           (count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic f, input logic iv, input logic orr,
                                 input logic [63:0] pc, input logic [31:0] instr,
                                 input logic taken, input logic [63:0] target,
                                 input logic exv, input logic [63:0] cause);
        flush          = f;
        in_valid       = iv;
        out_ready      = orr;
        in_pc          = pc;
        in_instr       = instr;
        in_pred_taken  = taken;
        in_pred_target = target;
        in_ex_valid    = exv;
        in_ex_cause    = cause;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    initial begin
        ent_t        e;
        ent_t        head;
        logic        exp_ready;
        logic        exp_valid;
        logic        bypass;
        logic        do_push;
        logic        do_pop;
        logic [63:0] exp_pc;
        int          exp_cnt;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();

        // Fill/drain table: flush, in_valid, out_ready, pc, exp ready, exp valid, exp pc, exp count.
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 64'h00, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h80, 1'b1, BYP,  64'h80, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h84, 1'b1, 1'b1, 64'h80, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h88, 1'b1, 1'b1, 64'h80, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h8C, 1'b1, 1'b1, 64'h80, 3});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h90, 1'b0, 1'b1, 64'h80, 4});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h94, 1'b0, 1'b1, 64'h80, 4});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h00, 1'b1, 1'b1, 64'h84, 3});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h00, 1'b1, 1'b1, 64'h88, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h00, 1'b1, 1'b1, 64'h8C, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 64'h00, 0});

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_pc", out_pc, 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_taken", 64'(out_pred_taken), 64'd0);
        checkOutput("rst_out_target", out_pred_target, 64'd0);
        checkOutput("rst_out_exv", 64'(out_ex_valid), 64'd0);
        checkOutput("rst_out_cause", out_ex_cause, 64'd0);

        // Table-driven fill to full, refused pushes, in-order drain
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].pc,
                          32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
            checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            if (vecs[i].exp_out_valid) begin
                checkOutput($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
                checkOutput($sformatf("vec%0d_instr", i), 64'(out_instr), 64'h13);
            end
            tick();
        end

        // Wrap-around streaming with simultaneous push and pop
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b0, i < 10, 1'b1, 64'h400 + 64'(4 * i), 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
            #1;
            exp_cnt   = BYP ? 0 : ((i == 0) ? 0 : 1);
            exp_valid = BYP ? (i < 10) : (i != 0);
            exp_pc    = BYP ? 64'h400 + 64'(4 * i) : 64'h400 + 64'(4 * (i - 1));
            checkOutput($sformatf("wrap%0d_count", i), 64'(count), 64'(exp_cnt));
            checkOutput($sformatf("wrap%0d_valid", i), 64'(out_valid), 64'(exp_valid));
            if (exp_valid) checkOutput($sformatf("wrap%0d_pc", i), out_pc, exp_pc);
            tick();
        end
        idle();
        #1;
        checkOutput("wrap_drained", 64'(count), 64'd0);

        // Flush with three entries queued, concurrent push and pop masked
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 64'h100 + 64'(4 * i), 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h200, 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
        #1;
        checkOutput("flush_count_before", 64'(count), 64'd3);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h300, 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
        #1;
        checkOutput("flush_count_after", 64'(count), 64'd0);
        tick();
        idle();
        #1;
        checkOutput("flush_next_count", 64'(count), 64'd1);
        checkOutput("flush_next_pc", out_pc, 64'h300);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 1'b0, 64'd0, 1'b0, 64'd0);
        tick();

        // Exception entry followed by a non-fault entry whose cause must read zero
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h1000, 32'h13, 1'b1, 64'h2000, 1'b1, 64'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h1004, 32'h33, 1'b0, 64'h0, 1'b0, 64'hDEAD);
        #1;
        checkOutput("exc_valid", 64'(out_valid), 64'd1);
        checkOutput("exc_pc", out_pc, 64'h1000);
        checkOutput("exc_exv", 64'(out_ex_valid), 64'd1);
        checkOutput("exc_cause", out_ex_cause, 64'd1);
        checkOutput("exc_taken", 64'(out_pred_taken), 64'd1);
        checkOutput("exc_target", out_pred_target, 64'h2000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 1'b0, 64'd0, 1'b0, 64'd0);
        #1;
        checkOutput("noexc_pc", out_pc, 64'h1004);
        checkOutput("noexc_instr", 64'(out_instr), 64'h33);
        checkOutput("noexc_exv", 64'(out_ex_valid), 64'd0);
        checkOutput("noexc_cause", out_ex_cause, 64'd0);
        tick();

        // Asynchronous reset between edges with two entries queued
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 64'h500 + 64'(4 * i), 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
            tick();
        end
        idle();
        #3;
        checkOutput("arst_count_before", 64'(count), 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_count", 64'(count), 64'd0);
        checkOutput("arst_out_pc", out_pc, 64'd0);
        #7;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h600, 32'h13, 1'b0, 64'd0, 1'b0, 64'd0);
        #1;
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 64'd0, 32'd0, 1'b0, 64'd0, 1'b0, 64'd0);
        #1;
        checkOutput("arst_push_count", 64'(count), 64'd1);
        checkOutput("arst_push_pc", out_pc, 64'h600);
        tick();

        // Randomized traffic against a queue reference model
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            e.pc     = {$urandom, $urandom};
            e.instr  = $urandom;
            e.taken  = 1'($urandom_range(0, 1));
            e.target = {$urandom, $urandom};
            e.exv    = ($urandom_range(0, 3) == 0);
            e.cause  = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 6), e.pc, e.instr, e.taken, e.target,
                          e.exv, e.cause);
            if (!e.exv) e.cause = 64'd0;
            #1;
            bypass    = BYP && (model_q.size() == 0) && !flush;
            exp_ready = (model_q.size() < DEPTH) && !flush;
            exp_valid = bypass ? in_valid : ((model_q.size() != 0) && !flush);
            head      = bypass ? e : ((model_q.size() != 0) ? model_q[0] : e);
            checkOutput("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
            checkOutput("rnd_out_valid", 64'(out_valid), 64'(exp_valid));
            checkOutput("rnd_count", 64'(count), 64'(model_q.size()));
            if (exp_valid) begin
                checkOutput("rnd_pc", out_pc, head.pc);
                checkOutput("rnd_instr", 64'(out_instr), 64'(head.instr));
                checkOutput("rnd_taken", 64'(out_pred_taken), 64'(head.taken));
                checkOutput("rnd_target", out_pred_target, head.target);
                checkOutput("rnd_exv", 64'(out_ex_valid), 64'(head.exv));
                checkOutput("rnd_cause", out_ex_cause, head.cause);
            end
            do_push = in_valid && exp_ready;
            do_pop  = exp_valid && out_ready;
            if (flush) begin
                model_q.delete();
            end else if (!(bypass && do_push && do_pop)) begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back(e);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
